// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/wait/writeback sequencer for the iterative mult/div units
module multdiv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic             op_is_div,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] op_tag,
    output logic             busy,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [31:0]      unit_a,
    output logic [31:0]      unit_b,
    input  logic             unit_rdy,
    input  logic [31:0]      unit_result,
    input  logic             unit_exc,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_result,
    output logic             wb_exception,
    output logic             wb_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             ctrl_mult_q, ctrl_mult_d;
    logic             ctrl_div_q, ctrl_div_d;
    logic [31:0]      unit_a_q, unit_a_d;
    logic [31:0]      unit_b_q, unit_b_d;
    logic             wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [31:0]      wb_result_q, wb_result_d;
    logic             wb_exception_q, wb_exception_d;
    logic             wb_timeout_q, wb_timeout_d;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        sel_d          = sel_q;
        unit_a_d       = unit_a_q;
        unit_b_d       = unit_b_q;
        wb_valid_d     = wb_valid_q;
        wb_tag_d       = wb_tag_q;
        wb_result_d    = wb_result_q;
        wb_exception_d = wb_exception_q;
        wb_timeout_d   = wb_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    unit_a_d = op_a;
                    unit_b_d = op_b;
                    wb_tag_d = op_tag;
                    sel_d    = op_is_div;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // unit_rdy here may be a leftover from the previous op, so it is not looked at
                count_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (count_q != CNT_W'(TIMEOUT_CYCLES)) begin
                    count_d = count_q + 1'b1;
                end
                if (unit_rdy) begin
                    wb_result_d    = unit_exc ? 32'd0 : unit_result;
                    wb_exception_d = unit_exc;
                    wb_timeout_d   = 1'b0;
                    wb_valid_d     = 1'b1;
                    state_d        = S_HOLD;
                end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    wb_result_d    = 32'd0;
                    wb_exception_d = 1'b1;
                    wb_timeout_d   = 1'b1;
                    wb_valid_d     = 1'b1;
                    state_d        = S_HOLD;
                end
            end
            S_HOLD: begin
                if (wb_ready) begin
                    wb_valid_d     = 1'b0;
                    wb_exception_d = 1'b0;
                    wb_timeout_d   = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        busy_d      = (state_d != S_IDLE);
        ctrl_div_d  = (state_d == S_ISSUE) &&  sel_d;
        ctrl_mult_d = (state_d == S_ISSUE) && !sel_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            sel_q          <= 1'b0;
            busy_q         <= 1'b0;
            ctrl_mult_q    <= 1'b0;
            ctrl_div_q     <= 1'b0;
            unit_a_q       <= '0;
            unit_b_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_tag_q       <= '0;
            wb_result_q    <= '0;
            wb_exception_q <= 1'b0;
            wb_timeout_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            sel_q          <= sel_d;
            busy_q         <= busy_d;
            ctrl_mult_q    <= ctrl_mult_d;
            ctrl_div_q     <= ctrl_div_d;
            unit_a_q       <= unit_a_d;
            unit_b_q       <= unit_b_d;
            wb_valid_q     <= wb_valid_d;
            wb_tag_q       <= wb_tag_d;
            wb_result_q    <= wb_result_d;
            wb_exception_q <= wb_exception_d;
            wb_timeout_q   <= wb_timeout_d;
        end
    end

    assign busy         = busy_q;
    assign ctrl_MULT    = ctrl_mult_q;
    assign ctrl_DIV     = ctrl_div_q;
    assign unit_a       = unit_a_q;
    assign unit_b       = unit_b_q;
    assign wb_valid     = wb_valid_q;
    assign wb_tag       = wb_tag_q;
    assign wb_result    = wb_result_q;
    assign wb_exception = wb_exception_q;
    assign wb_timeout   = wb_timeout_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid, op_is_div;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_tag;
    logic        busy, ctrl_MULT, ctrl_DIV;
    logic [31:0] unit_a, unit_b;
    logic        unit_rdy, unit_exc;
    logic [31:0] unit_result;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_tag;
    logic [31:0] wb_result;
    logic        wb_exception, wb_timeout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TO), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
        .busy(busy), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .unit_a(unit_a), .unit_b(unit_b),
        .unit_rdy(unit_rdy), .unit_result(unit_result), .unit_exc(unit_exc),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_result(wb_result), .wb_exception(wb_exception), .wb_timeout(wb_timeout)
    );

    typedef struct {
        logic        is_div;
        logic [31:0] a, b;
        logic [4:0]  tag;
        int          rdy_cyc;   // cycle after accept (0 = ISSUE) in which unit_rdy is driven
        logic        rdy_hold;  // keep unit_rdy high from rdy_cyc onward
        logic        exc;
        logic [31:0] res;
        int          hold;      // cycles wb_ready stays low in HOLD
        logic        pend;      // present a second op during HOLD
        logic [31:0] exp_res;
        logic        exp_exc, exp_to;
        int          exp_lat;   // cycle after accept in which wb_valid is first seen
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] all_out();
        return {31'd0, busy | ctrl_MULT | ctrl_DIV | wb_valid | wb_exception | wb_timeout
                | (|unit_a) | (|unit_b) | (|wb_tag) | (|wb_result)};
    endfunction

    // Transaction-level reference: when does the first usable RDY arrive, and what does writeback see
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int first = -1;
        if (v.rdy_hold) first = (v.rdy_cyc < 1) ? 1 : v.rdy_cyc;
        else if (v.rdy_cyc >= 1) first = v.rdy_cyc;
        if (first >= 1 && first <= TO) begin
            r.exp_lat = first + 1;
            r.exp_res = v.exc ? 32'd0 : v.res;
            r.exp_exc = v.exc;
            r.exp_to  = 1'b0;
        end else begin
            r.exp_lat = TO + 1;
            r.exp_res = 32'd0;
            r.exp_exc = 1'b1;
            r.exp_to  = 1'b1;
        end
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string nm);
        int lat = -1;
        int ndiv = 0;
        int nmult = 0;
        logic ok = 1'b1;
        logic [31:0] r0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        check({nm, "_idle"}, busy, 0);
        op_valid = 1; op_is_div = v.is_div; op_a = v.a; op_b = v.b; op_tag = v.tag;
        @(negedge clk);
        op_valid = 0; op_a = $urandom; op_b = $urandom; op_tag = 5'($urandom);
        check({nm, "_unit_a"}, unit_a, v.a);
        check({nm, "_unit_b"}, unit_b, v.b);
        for (int c = 0; c < 60; c++) begin
            if (ctrl_DIV) ndiv++;
            if (ctrl_MULT) nmult++;
            if (wb_valid) begin lat = c; break; end
            if (!busy || unit_a !== v.a || unit_b !== v.b) ok = 1'b0;
            unit_rdy    = (c == v.rdy_cyc) || (v.rdy_hold && c >= v.rdy_cyc);
            unit_exc    = v.exc;
            unit_result = v.res;
            @(negedge clk);
        end
        unit_rdy = 0; unit_exc = 0; unit_result = $urandom;
        check({nm, "_operands_stable"}, ok, 1);
        check({nm, "_ctrl_div"}, ndiv, v.is_div ? 1 : 0);
        check({nm, "_ctrl_mult"}, nmult, v.is_div ? 0 : 1);
        check({nm, "_latency"}, lat, v.exp_lat);
        check({nm, "_result"}, wb_result, v.exp_res);
        check({nm, "_exception"}, wb_exception, v.exp_exc);
        check({nm, "_timeout"}, wb_timeout, v.exp_to);
        check({nm, "_tag"}, wb_tag, v.tag);
        r0 = wb_result;
        ok = 1'b1;
        if (v.pend) begin op_valid = 1; op_is_div = 1; op_a = 32'hA5A5_0001; op_b = 32'h3; op_tag = 5'h11; end
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (!(wb_valid && busy && wb_result === r0 && wb_tag === v.tag && !ctrl_DIV && !ctrl_MULT
                  && wb_exception === v.exp_exc && wb_timeout === v.exp_to)) ok = 1'b0;
        end
        check({nm, "_hold_stable"}, ok, 1);
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
        check({nm, "_wb_clear"}, {wb_valid, wb_exception, wb_timeout, busy}, 4'b0000);
        check({nm, "_result_kept"}, wb_result, r0);
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        reset_n = 0; op_valid = 0; op_is_div = 0; op_a = 0; op_b = 0; op_tag = 0;
        unit_rdy = 0; unit_exc = 0; unit_result = 0; wb_ready = 0;
        // is_div a b tag rdy_cyc hold exc res hold pend exp_res exp_exc exp_to exp_lat
        vecs[0] = '{1'b1, 32'd100, 32'd7, 5'h0A, 34, 1'b0, 1'b0, 32'd14, 0, 1'b0, 32'd14, 1'b0, 1'b0, 35};
        vecs[1] = '{1'b1, 32'd55, 32'd0, 5'h03, 5, 1'b0, 1'b1, 32'hDEAD, 1, 1'b0, 32'd0, 1'b1, 1'b0, 6};
        vecs[2] = '{1'b0, 32'd3, 32'hFFFF_FFFB, 5'h07, 0, 1'b1, 1'b0, 32'hFFFF_FFF1, 0, 1'b0, 32'hFFFF_FFF1, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 32'h1234, 32'h5, 5'h1F, 99, 1'b0, 1'b0, 32'hBEEF, 2, 1'b0, 32'd0, 1'b1, 1'b1, 41};
        vecs[4] = '{1'b0, 32'h77, 32'h2, 5'h15, 40, 1'b0, 1'b0, 32'hEE, 0, 1'b0, 32'hEE, 1'b0, 1'b0, 41};
        vecs[5] = '{1'b0, 32'h9, 32'h9, 5'h02, 0, 1'b0, 1'b0, 32'h51, 0, 1'b0, 32'd0, 1'b1, 1'b1, 41};
        vecs[6] = '{1'b0, 32'hCAFE, 32'h10, 5'h0C, 1, 1'b0, 1'b0, 32'hCAFE0, 5, 1'b1, 32'hCAFE0, 1'b0, 1'b0, 2};

        repeat (2) @(negedge clk);
        check("reset_outputs", all_out(), 0);
        reset_n = 1;
        @(negedge clk);
        check("idle_after_reset", all_out(), 0);

        for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // vec6 left a divide pending through HOLD; it is accepted in the first IDLE cycle
        @(negedge clk);
        op_valid = 0;
        check("pend_ctrl", {ctrl_DIV, ctrl_MULT, busy}, 3'b101);
        check("pend_operand", unit_a, 32'hA5A5_0001);
        unit_rdy = 1; unit_result = 32'h1234;
        repeat (2) @(negedge clk);
        unit_rdy = 0;
        check("pend_wb", {wb_valid, wb_tag, wb_result}, {1'b1, 5'h11, 32'h1234});
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;

        for (int n = 0; n < 20; n++) begin
            rv.is_div = 1'($urandom); rv.a = $urandom; rv.b = $urandom; rv.tag = 5'($urandom);
            rv.rdy_cyc = $urandom_range(0, 45); rv.rdy_hold = 1'($urandom);
            rv.exc = ($urandom_range(0, 3) == 0); rv.res = $urandom;
            rv.hold = $urandom_range(0, 3); rv.pend = 1'b0;
            run_op(model(rv), $sformatf("rnd%0d", n));
        end

        // Reset in the middle of WAIT, then a stray RDY from the aborted op
        op_valid = 1; op_is_div = 1; op_a = 32'h42; op_b = 32'h6; op_tag = 5'h09;
        @(negedge clk);
        op_valid = 0;
        repeat (6) @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        check("midreset_outputs", all_out(), 0);
        reset_n = 1;
        unit_rdy = 1; unit_result = 32'hFFFF;
        @(negedge clk);
        unit_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stray_rdy_%0d", i), all_out(), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
